dsp_sub_i8_i8_i8: RTL and testbench

//   Signed 8-bit subtractor, y = a - b, mapped as a DSP-slice style arithmetic

---
 rtl/dsp_sub_i8_i8_i8.sv | 43 ++++
 tb/tb_dsp_sub_i8_i8_i8.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dsp_sub_i8_i8_i8.sv
// Signed 8-bit DSP-style subtractor, y = a - b (wrapping).
// Optional output register models the DSP P-register.
module dsp_sub_i8_i8_i8 #(
  parameter int WIDTH   = 8,
  parameter bit OUT_REG = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] w_diff;

  // Modular difference; signed and unsigned views share bits
  always_comb begin
    w_diff = a - b;
  end

  generate
    if (OUT_REG) begin : g_reg
      logic [WIDTH-1:0] r_y;

      // P-register: async clear, loads difference every edge
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_y <= '0;
        end else begin
          r_y <= w_diff;
        end
      end

      assign y = r_y;
    end else begin : g_comb
      // clock/reset kept only for library port uniformity
      logic w_unused_ok;
      assign w_unused_ok = &{1'b0, clock, reset};
      assign y = w_diff;
    end
  endgenerate

endmodule

// File: tb/tb_dsp_sub_i8_i8_i8.sv
// Scoreboard bench for dsp_sub_i8_i8_i8, both build variants.
// Directed, boundary and random operands vs a reference model.
module tb_dsp_sub_i8_i8_i8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic [7:0] y0;
  logic [7:0] y1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         mon_en = 1'b0;

  always #5 clock = ~clock;

  dsp_sub_i8_i8_i8 #(.WIDTH(8), .OUT_REG(1'b0)) u_comb (
    .clock(clock),
    .reset(reset),
    .a    (a),
    .b    (b),
    .y    (y0)
  );

  dsp_sub_i8_i8_i8 #(.WIDTH(8), .OUT_REG(1'b1)) u_reg (
    .clock(clock),
    .reset(reset),
    .a    (a),
    .b    (b),
    .y    (y1)
  );

  function automatic logic [7:0] model(input logic [7:0] x,
                                       input logic [7:0] z);
    int d;
    d = int'($signed(x)) - int'($signed(z));
    d = ((d % 256) + 256) % 256;
    return 8'(d);
  endfunction

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %02h want %02h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [7:0] xa, input logic [7:0] xb,
                       input logic [7:0] exp);
    @(posedge clock);
    #2;
    a = xa;
    b = xb;
    q0.push_back(exp);
    q1.push_back(exp);
  endtask

  always @(negedge clock) begin
    if (mon_en && q0.size() > 0) begin
      check("comb_y", y0, q0.pop_front());
    end
  end

  always @(posedge clock) begin
    #1;
    if (mon_en && q1.size() > 0) begin
      check("reg_y", y1, q1.pop_front());
    end
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    a = 8'd8;
    b = 8'd33;
    #1 reset = 1'b1;
    #1;
    check("reset_async_reg", y1, 8'h00);
    check("reset_comb", y0, 8'hE7);

    for (int i = 0; i < 16; i++) begin
      @(posedge clock);
      #1;
      check("hold_reg", y1, 8'h00);
      check("hold_comb", y0, 8'hE7);
    end
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    check("first_edge_reg", y1, 8'hE7);
    check("first_edge_comb", y0, 8'hE7);

    mon_en = 1'b1;
    issue(8'd33,  8'd8,   8'd25);
    issue(8'd0,   8'd1,   8'hFF);
    issue(8'h5A,  8'h5A,  8'h00);
    issue(8'h80,  8'h01,  8'h7F);
    issue(8'h7F,  8'hFF,  8'h80);
    issue(8'd8,   8'd33,  8'hE7);
    issue(8'h00,  8'h80,  8'h80);
    issue(8'hFF,  8'hFF,  8'h00);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      issue(ra, rb, model(ra, rb));
    end
    repeat (2) @(negedge clock);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d want 0/0", q0.size(), q1.size());
    end
    mon_en = 1'b0;

    @(posedge clock);
    #2;
    a = 8'h11;
    b = 8'h22;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_reset_now", y1, 8'h00);
    repeat (2) begin
      @(posedge clock);
      #1;
      check("mid_reset_hold", y1, 8'h00);
    end
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    check("mid_reset_release", y1, model(8'h11, 8'h22));

    a = 8'd8;
    b = 8'd33;
    for (int i = 0; i < 6; i++) begin
      #3 reset = ~reset;
      #1;
      check("stable_comb", y0, 8'hE7);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
